// File: rtl/aes_block_serializer_if.sv
// aes_block_serializer_if: 32-bit word stream from the block serializer to its consumer.
// Latency: none, this is a plain bundle of wires.
// Backpressure: the consumer holds out_ready low to stall; the producer keeps out_data stable.
// Ports: out_valid/out_data/out_last from producer, out_ready from consumer.
interface aes_block_serializer_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  // Producer side (the serializer).
  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  // Consumer side (CPU bridge or testbench).
  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/aes_block_serializer.sv
// aes_block_serializer: captures each 128-bit AES result block on a rising blk_done level,
// buffers up to DEPTH blocks and streams each one as four 32-bit words.
// Latency: the first word is valid the cycle after the done edge is sampled.
// Backpressure: out_ready low holds the current word; a full buffer drops new blocks and sets overflow.
// Ports:
//   clk, resetn      - clock, asynchronous active-low reset
//   blk_done         - core done level; a 0->1 transition marks a new block on blk_data
//   blk_data         - core result block, sampled in the capture cycle
//   out_bus          - word stream (valid/ready/data/last), master side
//   blocks_avail     - number of buffered blocks (registered)
//   overflow/ovf_clr - sticky dropped-block flag and its synchronous clear
//   flush            - synchronous discard of all buffered blocks
module aes_block_serializer #(
  parameter  int DEPTH     = 2,
  parameter  bit MSW_FIRST = 1'b1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   blk_done,
  input  logic [127:0]           blk_data,
  aes_block_serializer_if.master out_bus,
  output logic [CW-1:0]          blocks_avail,
  output logic                   overflow,
  input  logic                   ovf_clr,
  input  logic                   flush
);

  // A single-slot buffer still needs a 1-bit pointer; it simply never leaves 0.
  localparam int                PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]     LAST_SLOT = PW'(DEPTH - 1);
  localparam logic [CW-1:0]     FULL_CNT  = CW'(DEPTH);

  logic          done_q;
  logic [1:0]    word_idx;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [127:0]  slot_mem [DEPTH];

  logic          cap;
  logic          xfer;
  logic          pop;
  logic          full;
  logic          accept;
  logic          drop;
  logic [127:0]  head;
  logic [1:0]    sel;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PW'(1);
  endfunction

  // The core holds done high for as long as the result is valid, so only the
  // rising edge counts as a new block.
  assign cap  = blk_done & ~done_q;
  assign xfer = out_bus.out_valid & out_bus.out_ready;
  assign pop  = xfer & (word_idx == 2'd3);
  assign full = (count == FULL_CNT);

  // A full buffer can still take a block if the head block leaves in the same
  // cycle. Flush wins over everything, and a block arriving with flush is
  // silently discarded rather than counted as an overflow.
  assign accept = cap & ~flush & (~full | pop);
  assign drop   = cap & ~flush & full & ~pop;

  // Block storage: no reset needed, the count gates every read.
  always_ff @(posedge clk) begin
    if (accept) begin
      slot_mem[wr_ptr] <= blk_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // done_q starts high so a done level already present at release is
      // treated as stale, not as a fresh block.
      done_q   <= 1'b1;
      word_idx <= 2'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      done_q <= blk_done;

      if (flush) begin
        word_idx <= 2'd0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (xfer) begin
          word_idx <= (word_idx == 2'd3) ? 2'd0 : word_idx + 2'd1;
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        if (accept) begin
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (accept && !pop) begin
          count <= count + CW'(1);
        end else if (pop && !accept) begin
          count <= count - CW'(1);
        end
      end

      // A drop in the same cycle as the clear must stay visible.
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Word 0 is either the most- or least-significant 32 bits of the block.
  always_comb begin
    head = slot_mem[rd_ptr];
    sel  = MSW_FIRST ? (2'd3 - word_idx) : word_idx;
  end

  assign out_bus.out_valid = (count != '0);
  // Zero when idle keeps the bus at a defined value out of reset, before any
  // slot has been written.
  assign out_bus.out_data  = out_bus.out_valid ? head[{sel, 5'd0} +: 32] : 32'd0;
  assign out_bus.out_last  = out_bus.out_valid & (word_idx == 2'd3);
  assign blocks_avail      = count;

  // Occupancy can never exceed the slot count.
  a_count_bound: assert property (@(posedge clk) disable iff (!resetn)
    count <= FULL_CNT);

  // A stalled word must not change until the consumer takes it.
  a_stall_stable: assert property (@(posedge clk) disable iff (!resetn)
    (out_bus.out_valid && !out_bus.out_ready && !flush)
      |=> (out_bus.out_valid && $stable(out_bus.out_data)));

endmodule

// File: tb/tb_aes_block_serializer.sv
module tb_aes_block_serializer;

  localparam logic [127:0] BLK_F = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] BLK_B = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] BLK_C = 128'hdeadbeef_cafef00d_0badc0de_12345678;

  logic         clk = 1'b0;
  logic         resetn;
  logic         blk_done;
  logic [127:0] blk_data;
  logic [1:0]   blocks_avail;
  logic         overflow;
  logic         ovf_clr;
  logic         flush;

  logic         done2;
  logic [127:0] data2;
  logic [1:0]   avail2;
  logic         ovf2;
  logic         ovf_clr2;
  logic         flush2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] got_d[$];
  logic        got_l[$];
  int          got_c[$];

  always #5 clk = ~clk;

  aes_block_serializer_if bus ();
  aes_block_serializer_if bus2 ();

  aes_block_serializer #(.DEPTH(2), .MSW_FIRST(1'b1)) u_dut (
    .clk          (clk),
    .resetn       (resetn),
    .blk_done     (blk_done),
    .blk_data     (blk_data),
    .out_bus      (bus),
    .blocks_avail (blocks_avail),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr),
    .flush        (flush)
  );

  aes_block_serializer #(.DEPTH(2), .MSW_FIRST(1'b0)) u_dut_lsw (
    .clk          (clk),
    .resetn       (resetn),
    .blk_done     (done2),
    .blk_data     (data2),
    .out_bus      (bus2),
    .blocks_avail (avail2),
    .overflow     (ovf2),
    .ovf_clr      (ovf_clr2),
    .flush        (flush2)
  );

  // One cycle: at the falling edge set out_ready and record any word that will
  // transfer on the coming rising edge.
  task automatic tick(input logic rdy);
    @(negedge clk);
    cyc++;
    bus.out_ready = rdy;
    if (bus.out_valid && rdy) begin
      got_d.push_back(bus.out_data);
      got_l.push_back(bus.out_last);
      got_c.push_back(cyc);
    end
  endtask

  task automatic clear_got();
    got_d.delete();
    got_l.delete();
    got_c.delete();
  endtask

  // One done pulse (one cycle high, one cycle low) with out_ready held low.
  task automatic load(input logic [127:0] d);
    blk_done = 1'b1;
    blk_data = d;
    tick(1'b0);
    blk_done = 1'b0;
    tick(1'b0);
  endtask

  task automatic test_reset();
    tick(1'b0);
    tick(1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b expected 0", bus.out_last); end
    n_checks++;
    if (bus.out_data !== 32'd0) begin n_fail++; $display("FAIL rst_data: got %h expected 00000000", bus.out_data); end
    n_checks++;
    if (blocks_avail !== 2'd0) begin n_fail++; $display("FAIL rst_avail: got %0d expected 0", blocks_avail); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
    resetn = 1'b1;
    tick(1'b0);
    tick(1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_basic();
    logic [31:0] exp [4] = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
    int c0;
    clear_got();
    tick(1'b1);
    blk_done = 1'b1;
    blk_data = BLK_F;
    c0 = cyc;
    for (int i = 0; i < 10; i++) tick(1'b1);
    blk_done = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1);
    n_checks++;
    if (got_d.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d words expected 4", got_d.size()); end
    for (int k = 0; k < 4 && k < got_d.size(); k++) begin
      n_checks++;
      if (got_d[k] !== exp[k]) begin n_fail++; $display("FAIL basic_word%0d: got %h expected %h", k, got_d[k], exp[k]); end
      n_checks++;
      if (got_l[k] !== (k == 3)) begin n_fail++; $display("FAIL basic_last%0d: got %b expected %b", k, got_l[k], (k == 3)); end
      n_checks++;
      if (got_c[k] != c0 + 1 + k) begin n_fail++; $display("FAIL basic_cycle%0d: got %0d expected %0d", k, got_c[k], c0 + 1 + k); end
    end
    n_checks++;
    if (blocks_avail !== 2'd0) begin n_fail++; $display("FAIL basic_avail: got %0d expected 0", blocks_avail); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_back_pressure();
    logic        pat    [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_d  [7] = '{32'h69c4e0d8, 32'h6a7b0430, 32'h6a7b0430, 32'h6a7b0430,
                                32'hd8cdb780, 32'hd8cdb780, 32'h70b4c55a};
    logic        exp_l  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    clear_got();
    tick(1'b0);
    blk_done = 1'b1;
    blk_data = BLK_F;
    for (int i = 0; i < 7; i++) begin
      tick(pat[i]);
      n_checks++;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid%0d: got %b expected 1", i, bus.out_valid); end
      n_checks++;
      if (bus.out_data !== exp_d[i]) begin n_fail++; $display("FAIL bp_data%0d: got %h expected %h", i, bus.out_data, exp_d[i]); end
      n_checks++;
      if (bus.out_last !== exp_l[i]) begin n_fail++; $display("FAIL bp_last%0d: got %b expected %b", i, bus.out_last, exp_l[i]); end
    end
    blk_done = 1'b0;
    tick(1'b1);
    tick(1'b1);
    n_checks++;
    if (got_d.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d words expected 4", got_d.size()); end
    n_checks++;
    if (blocks_avail !== 2'd0) begin n_fail++; $display("FAIL bp_avail: got %0d expected 0", blocks_avail); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp [8] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff,
                             32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};
    clear_got();
    load(BLK_A);
    load(BLK_B);
    load(BLK_C);
    n_checks++;
    if (blocks_avail !== 2'd2) begin n_fail++; $display("FAIL ovf_avail: got %0d expected 2", blocks_avail); end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    for (int i = 0; i < 12; i++) tick(1'b1);
    n_checks++;
    if (got_d.size() != 8) begin n_fail++; $display("FAIL ovf_count: got %0d words expected 8", got_d.size()); end
    for (int k = 0; k < 8 && k < got_d.size(); k++) begin
      n_checks++;
      if (got_d[k] !== exp[k]) begin n_fail++; $display("FAIL ovf_word%0d: got %h expected %h", k, got_d[k], exp[k]); end
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    ovf_clr = 1'b1;
    tick(1'b1);
    ovf_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp [12] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff,
                              32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210,
                              32'hdeadbeef, 32'hcafef00d, 32'h0badc0de, 32'h12345678};
    clear_got();
    load(BLK_A);
    load(BLK_B);
    n_checks++;
    if (blocks_avail !== 2'd2) begin n_fail++; $display("FAIL fp_full: got %0d expected 2", blocks_avail); end
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    n_checks++;
    if (bus.out_last !== 1'b1) begin n_fail++; $display("FAIL fp_last_seen: got %b expected 1", bus.out_last); end
    // C's done edge lands on the same rising edge as A's final word transfer.
    blk_done = 1'b1;
    blk_data = BLK_C;
    tick(1'b1);
    blk_done = 1'b0;
    n_checks++;
    if (blocks_avail !== 2'd2) begin n_fail++; $display("FAIL fp_avail: got %0d expected 2", blocks_avail); end
    for (int i = 0; i < 10; i++) tick(1'b1);
    n_checks++;
    if (got_d.size() != 12) begin n_fail++; $display("FAIL fp_count: got %0d words expected 12", got_d.size()); end
    for (int k = 0; k < 12 && k < got_d.size(); k++) begin
      n_checks++;
      if (got_d[k] !== exp[k]) begin n_fail++; $display("FAIL fp_word%0d: got %h expected %h", k, got_d[k], exp[k]); end
    end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL fp_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_flush();
    load(BLK_A);
    load(BLK_B);
    // Drop and clear in the same cycle: the drop must win.
    blk_done = 1'b1;
    blk_data = BLK_C;
    ovf_clr  = 1'b1;
    tick(1'b0);
    blk_done = 1'b0;
    ovf_clr  = 1'b0;
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL fl_setwins: got %b expected 1", overflow); end
    n_checks++;
    if (blocks_avail !== 2'd2) begin n_fail++; $display("FAIL fl_held: got %0d expected 2", blocks_avail); end
    flush = 1'b1;
    tick(1'b0);
    flush = 1'b0;
    n_checks++;
    if (blocks_avail !== 2'd0) begin n_fail++; $display("FAIL fl_avail: got %0d expected 0", blocks_avail); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL fl_ovf_kept: got %b expected 1", overflow); end
    ovf_clr = 1'b1;
    tick(1'b0);
    ovf_clr = 1'b0;
    load(BLK_A);
    load(BLK_B);
    // A capture in the flush cycle is discarded and does not count as a drop.
    flush    = 1'b1;
    blk_done = 1'b1;
    blk_data = BLK_C;
    tick(1'b0);
    flush    = 1'b0;
    blk_done = 1'b0;
    n_checks++;
    if (blocks_avail !== 2'd0) begin n_fail++; $display("FAIL fl_cap_avail: got %0d expected 0", blocks_avail); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL fl_cap_ovf: got %b expected 0", overflow); end
    tick(1'b1);
    tick(1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_quiet: got %b expected 0", bus.out_valid); end
    load(BLK_B);
    n_checks++;
    if (bus.out_data !== 32'h01234567) begin n_fail++; $display("FAIL fl_restart: got %h expected 01234567", bus.out_data); end
    for (int i = 0; i < 5; i++) tick(1'b1);
  endtask

  task automatic test_mid_reset();
    load(BLK_A);
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    n_checks++;
    if (bus.out_data !== 32'h8899aabb) begin n_fail++; $display("FAIL mr_partial: got %h expected 8899aabb", bus.out_data); end
    resetn   = 1'b0;
    blk_done = 1'b1;
    blk_data = BLK_F;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== 32'd0)
      begin n_fail++; $display("FAIL mr_outputs: got valid=%b last=%b data=%h expected 0 0 00000000", bus.out_valid, bus.out_last, bus.out_data); end
    n_checks++;
    if (blocks_avail !== 2'd0 || overflow !== 1'b0)
      begin n_fail++; $display("FAIL mr_status: got avail=%0d ovf=%b expected 0 0", blocks_avail, overflow); end
    tick(1'b1);
    tick(1'b1);
    resetn = 1'b1;
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b0 || blocks_avail !== 2'd0)
      begin n_fail++; $display("FAIL mr_no_capture: got valid=%b avail=%0d expected 0 0", bus.out_valid, blocks_avail); end
    blk_done = 1'b0;
    tick(1'b1);
    clear_got();
    blk_done = 1'b1;
    tick(1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h69c4e0d8)
      begin n_fail++; $display("FAIL mr_recapture: got valid=%b data=%h expected 1 69c4e0d8", bus.out_valid, bus.out_data); end
    blk_done = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b1);
    n_checks++;
    if (got_d.size() != 4) begin n_fail++; $display("FAIL mr_count: got %0d words expected 4", got_d.size()); end
    else begin
      n_checks++;
      if (got_d[3] !== 32'h70b4c55a) begin n_fail++; $display("FAIL mr_word3: got %h expected 70b4c55a", got_d[3]); end
    end
  endtask

  task automatic test_word_order();
    logic [31:0] exp [4] = '{32'h70b4c55a, 32'hd8cdb780, 32'h6a7b0430, 32'h69c4e0d8};
    logic [31:0] seen_d[$];
    logic        seen_l[$];
    @(negedge clk);
    done2 = 1'b1;
    data2 = BLK_F;
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus2.out_valid) begin
        seen_d.push_back(bus2.out_data);
        seen_l.push_back(bus2.out_last);
      end
    end
    done2 = 1'b0;
    n_checks++;
    if (seen_d.size() != 4) begin n_fail++; $display("FAIL lsw_count: got %0d words expected 4", seen_d.size()); end
    for (int k = 0; k < 4 && k < seen_d.size(); k++) begin
      n_checks++;
      if (seen_d[k] !== exp[k]) begin n_fail++; $display("FAIL lsw_word%0d: got %h expected %h", k, seen_d[k], exp[k]); end
      n_checks++;
      if (seen_l[k] !== (k == 3)) begin n_fail++; $display("FAIL lsw_last%0d: got %b expected %b", k, seen_l[k], (k == 3)); end
    end
    n_checks++;
    if (avail2 !== 2'd0 || ovf2 !== 1'b0) begin n_fail++; $display("FAIL lsw_status: got avail=%0d ovf=%b expected 0 0", avail2, ovf2); end
  endtask

  initial begin
    resetn         = 1'b0;
    blk_done       = 1'b0;
    blk_data       = '0;
    ovf_clr        = 1'b0;
    flush          = 1'b0;
    bus.out_ready  = 1'b0;
    done2          = 1'b0;
    data2          = '0;
    ovf_clr2       = 1'b0;
    flush2         = 1'b0;
    bus2.out_ready = 1'b0;

    test_reset();
    test_basic();
    test_back_pressure();
    test_overflow();
    test_full_pop();
    test_flush();
    test_mid_reset();
    test_word_order();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_block_serializer.md
Name: aes_block_serializer

Overview:
- Reader-side companion to the ASMD_Encryption/ASMD_Decryption cores.
- Captures each 128-bit result block when the core's level `done` rises, and buffers up to DEPTH blocks.
- Streams buffered blocks to the PicoRV32-side consumer as 32-bit words on a valid/ready handshake.
- Replaces software polling of `Dout` and tolerates consumer back-pressure across back-to-back blocks.

Parameters:
- DEPTH, 2, number of 128-bit block slots; power of two, at least 1.
- MSW_FIRST, 1, 1 = word 0 is bits [127:96], 0 = word 0 is bits [31:0].

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- blk_done  in  1  core `done` level; a rising edge marks a valid block.
- blk_data  in  128  core `Dout`; sampled in the same cycle the rising edge is detected.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  32  current word of the head block.
- out_last  out  1  out_data is word 3 of the block.
- blocks_avail  out  CW  blocks held in the buffer, where CW = $clog2(DEPTH+1).
- overflow  out  1  sticky: a block was dropped.
- ovf_clr  in  1  synchronous clear of overflow.
- flush  in  1  synchronous discard of all buffered blocks.

Behaviour:
- Reset values (resetn low, asynchronous):
  - out_valid = 0, out_last = 0, out_data = 0, blocks_avail = 0, overflow = 0.
  - Internal: word index = 0, write and read pointers = 0, done_q = 1.
- done_q = 1 at reset means a blk_done already high when reset is released is NOT captured. blk_done must go low, then high, to be captured.
- Edge detect: done_q <= blk_done every cycle; capture condition is cap = blk_done & ~done_q.
- Capture: on cap, write blk_data into slot[wr_ptr], wr_ptr wraps modulo DEPTH, count increments. The write is registered, so out_valid rises the cycle after cap at the earliest.
- Output:
  - out_valid = (count != 0).
  - out_data = word[word_idx] of slot[rd_ptr], combinational from registers.
  - out_last = out_valid & (word_idx == 3).
- Transfer: occurs when out_valid & out_ready.
  - On a transfer with word_idx < 3: word_idx increments.
  - On a transfer with word_idx == 3 (pop): word_idx returns to 0, rd_ptr wraps modulo DEPTH, count decrements.
- out_data must stay stable while out_valid & ~out_ready.
- Full (count == DEPTH):
  - cap is accepted only if a pop occurs in the same cycle; count is then unchanged.
  - Otherwise the block is dropped, overflow is set, and the pointers and count are unchanged.
- Simultaneous cap and pop when not full: count is unchanged and both pointers advance.
- Overflow clear: ovf_clr clears overflow. If ovf_clr and a new drop occur in the same cycle, set wins and overflow = 1.
- Flush:
  - Flush has priority over cap and pop in the same cycle.
  - It zeroes count, pointers and word_idx.
  - A cap in the flush cycle is discarded and does not set overflow.
  - overflow itself is unaffected by flush.
  - done_q still updates.
- blocks_avail = count; it reflects the registered value and updates the cycle after the event.
- Mid-operation reset: any partially streamed block is lost; after release, streaming restarts from an empty buffer.
- Word order with MSW_FIRST = 0: word 0 = [31:0], through word 3 = [127:96].

Test Plan:
- Basic streaming:
  - Stimulus: DEPTH = 2, MSW_FIRST = 1, out_ready = 1; raise blk_done with blk_data = 69c4e0d86a7b0430d8cdb78070b4c55a and hold it high 10 cycles.
  - Required: words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a on four consecutive cycles, out_last only on the 4th, exactly one capture, blocks_avail returns to 0.
- Back-pressure:
  - Stimulus: same block; toggle out_ready 1,0,0,1,0,1,1.
  - Required: out_data holds the same word on every stalled cycle; same 4-word sequence; no duplicated or skipped words.
- Overflow:
  - Stimulus: out_ready = 0; three done rising edges carrying blocks A, B, C.
  - Required: blocks_avail = 2 and overflow = 1. With out_ready = 1, output is A then B (8 words) and C is absent. Pulse ovf_clr, then overflow = 0.
- Full with simultaneous pop:
  - Stimulus: buffer holds A and B; a done edge carrying C arrives in the same cycle as A's word-3 transfer.
  - Required: C accepted, overflow stays 0, output order B then C.
- Reset and flush:
  - Stimulus: assert resetn low mid-block (after 2 words); release while blk_done is high.
  - Required: outputs at reset values, no capture until blk_done falls then rises.
  - Stimulus: pulse flush while 2 blocks are held.
  - Required: blocks_avail = 0 and out_valid = 0 next cycle; overflow unchanged.
- Word-order variant:
  - Stimulus: MSW_FIRST = 0 with the FIPS block.
  - Required: words 70b4c55a, d8cdb780, 6a7b0430, 69c4e0d8.
